// File: rtl/tv_pkg.sv
// Shared types and default sizing for the test-vector checker.
package tv_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      APPLY = 3'd1,
      WAIT  = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } tv_state_t;

   localparam int TV_IN_W  = 8;
   localparam int TV_OUT_W = 4;
   localparam int TV_DEPTH = 32;
   localparam int TV_LAT   = 1;

endpackage

// File: rtl/tv_store.sv
// Vector slot storage: one registered write port, one asynchronous read port,
// and per-slot valid bits that a clear invalidates in one cycle.
module tv_store
   import tv_pkg::*;
#(
   parameter int W     = 16,
   parameter int DEPTH = TV_DEPTH,
   parameter int AW    = $clog2(DEPTH)
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          clr,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata,
   output logic          rvalid
);

   logic [W-1:0]     mem_r [DEPTH];
   logic [DEPTH-1:0] valid_r;

   // Payload write; contents are only trusted through the valid bits, so no reset.
   always_ff @(posedge clk) begin
      if (we && !clr) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Valid bits: clear has priority over a write in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_r <= '0;
      end else if (clr) begin
         valid_r <= '0;
      end else if (we) begin
         valid_r[waddr] <= 1'b1;
      end
   end

   assign rdata  = mem_r[raddr];
   assign rvalid = valid_r[raddr];

endmodule

// File: rtl/tv_checker.sv
// Test-vector checker: applies stored stimuli to a DUT, waits LAT cycles,
// compares the masked response and keeps per-run statistics.
module tv_checker
   import tv_pkg::*;
#(
   parameter int IN_W        = TV_IN_W,
   parameter int OUT_W       = TV_OUT_W,
   parameter int DEPTH       = TV_DEPTH,
   parameter int LAT         = TV_LAT,
   parameter int STOP_ON_ERR = 0
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ld_we,
   input  logic [$clog2(DEPTH)-1:0]   ld_addr,
   input  logic [IN_W+2*OUT_W-1:0]    ld_data,
   input  logic                       clr_vec,
   input  logic                       start,
   output logic [IN_W-1:0]            stim,
   input  logic [OUT_W-1:0]           dut_out,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(DEPTH+1)-1:0] vec_count,
   output logic [$clog2(DEPTH+1)-1:0] err_count,
   output logic [$clog2(DEPTH)-1:0]   first_err_idx,
   output logic                       first_err_vld
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH+1);
   localparam int DW  = IN_W + 2*OUT_W;
   localparam int WCW = (LAT > 2) ? $clog2(LAT) : 1;

   tv_state_t        state_r;
   logic [AW-1:0]    idx_r;
   logic [WCW-1:0]   wait_cnt_r;
   logic [IN_W-1:0]  stim_r;
   logic             busy_r;
   logic             done_r;
   logic [CW-1:0]    vec_count_r;
   logic [CW-1:0]    err_count_r;
   logic [AW-1:0]    first_err_idx_r;
   logic             first_err_vld_r;

   logic [DW-1:0]    slot_data_s;
   logic             slot_vld_s;
   logic [IN_W-1:0]  slot_stim_s;
   logic [OUT_W-1:0] slot_exp_s;
   logic [OUT_W-1:0] slot_mask_s;
   logic             mismatch_s;
   logic             idle_s;
   logic             store_we_s;
   logic             store_clr_s;

   tv_store #(.W(DW), .DEPTH(DEPTH), .AW(AW)) u_store (
      .clk    (clk),
      .reset  (reset),
      .we     (store_we_s),
      .waddr  (ld_addr),
      .wdata  (ld_data),
      .clr    (store_clr_s),
      .raddr  (idx_r),
      .rdata  (slot_data_s),
      .rvalid (slot_vld_s)
   );

   // Slot field split, masked compare and load gating (loads only outside a run).
   always_comb begin
      idle_s      = (state_r == IDLE) || (state_r == DONE);
      store_we_s  = ld_we & idle_s;
      store_clr_s = clr_vec & idle_s;
      slot_stim_s = slot_data_s[DW-1 -: IN_W];
      slot_exp_s  = slot_data_s[2*OUT_W-1 -: OUT_W];
      slot_mask_s = slot_data_s[OUT_W-1:0];
      mismatch_s  = |((dut_out ^ slot_exp_s) & slot_mask_s);
   end

   // Run sequencer with counters and first-error capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r         <= IDLE;
         idx_r           <= '0;
         wait_cnt_r      <= '0;
         stim_r          <= '0;
         busy_r          <= 1'b0;
         done_r          <= 1'b0;
         vec_count_r     <= '0;
         err_count_r     <= '0;
         first_err_idx_r <= '0;
         first_err_vld_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  vec_count_r     <= '0;
                  err_count_r     <= '0;
                  first_err_idx_r <= '0;
                  first_err_vld_r <= 1'b0;
                  done_r          <= 1'b0;
                  busy_r          <= 1'b1;
                  idx_r           <= '0;
                  state_r         <= APPLY;
               end
            end
            APPLY: begin
               if (!slot_vld_s) begin
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= DONE;
               end else begin
                  stim_r <= slot_stim_s;
                  if (LAT > 1) begin
                     wait_cnt_r <= WCW'((LAT > 1) ? (LAT - 2) : 0);
                     state_r    <= WAIT;
                  end else begin
                     state_r <= CHECK;
                  end
               end
            end
            WAIT: begin
               if (wait_cnt_r == '0) begin
                  state_r <= CHECK;
               end else begin
                  wait_cnt_r <= wait_cnt_r - WCW'(1);
               end
            end
            CHECK: begin
               vec_count_r <= vec_count_r + CW'(1);
               if (mismatch_s) begin
                  err_count_r <= err_count_r + CW'(1);
                  if (!first_err_vld_r) begin
                     first_err_idx_r <= idx_r;
                     first_err_vld_r <= 1'b1;
                  end
               end
               // The last slot ends the run here so idx never wraps.
               if ((idx_r == AW'(DEPTH - 1)) || ((STOP_ON_ERR != 0) && mismatch_s)) begin
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= DONE;
               end else begin
                  idx_r   <= idx_r + AW'(1);
                  state_r <= APPLY;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign stim          = stim_r;
   assign busy          = busy_r;
   assign done          = done_r;
   assign vec_count     = vec_count_r;
   assign err_count     = err_count_r;
   assign first_err_idx = first_err_idx_r;
   assign first_err_vld = first_err_vld_r;

endmodule

// File: tb/tb_tv_checker.sv
// Bench: three checker variants (default, stop-on-error, LAT=3) share one load
// bus and start strobe; each run is predicted by a slot-walking reference model.
module tb_tv_checker;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ld_we = 1'b0;
   logic [4:0] ld_addr = 5'd0;
   logic [15:0] ld_data = 16'd0;
   logic       clr_vec = 1'b0;
   logic       start = 1'b0;

   logic [7:0] stim_v [3];
   logic       busy_v [3];
   logic       done_v [3];
   logic [5:0] vc_v   [3];
   logic [5:0] ec_v   [3];
   logic [4:0] fidx_v [3];
   logic       fvld_v [3];
   logic [3:0] dout_d, dout_s, dout_l, pipe1, pipe2;

   logic [3:0] resp [256];
   int         stop_p [3] = '{0, 1, 0};
   int         lat_p  [3] = '{1, 1, 3};

   bit         m_valid [32];
   logic [7:0] m_stim  [32];
   logic [3:0] m_exp   [32];
   logic [3:0] m_mask  [32];
   logic [7:0] exp_stim [3];

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   // DUT responses: combinational lookups, and a two-register pipeline behind
   // the LAT=3 checker (three register stages counting its stim register).
   assign dout_d = resp[stim_v[0]];
   assign dout_s = resp[stim_v[1]];
   assign dout_l = pipe2;
   always @(posedge clk) begin
      pipe1 <= resp[stim_v[2]];
      pipe2 <= pipe1;
   end

   tv_checker u_def (
      .clk(clk), .reset(reset), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
      .clr_vec(clr_vec), .start(start), .stim(stim_v[0]), .dut_out(dout_d),
      .busy(busy_v[0]), .done(done_v[0]), .vec_count(vc_v[0]), .err_count(ec_v[0]),
      .first_err_idx(fidx_v[0]), .first_err_vld(fvld_v[0]));

   tv_checker #(.STOP_ON_ERR(1)) u_stop (
      .clk(clk), .reset(reset), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
      .clr_vec(clr_vec), .start(start), .stim(stim_v[1]), .dut_out(dout_s),
      .busy(busy_v[1]), .done(done_v[1]), .vec_count(vc_v[1]), .err_count(ec_v[1]),
      .first_err_idx(fidx_v[1]), .first_err_vld(fvld_v[1]));

   tv_checker #(.LAT(3)) u_lat (
      .clk(clk), .reset(reset), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
      .clr_vec(clr_vec), .start(start), .stim(stim_v[2]), .dut_out(dout_l),
      .busy(busy_v[2]), .done(done_v[2]), .vec_count(vc_v[2]), .err_count(ec_v[2]),
      .first_err_idx(fidx_v[2]), .first_err_vld(fvld_v[2]));

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input int addr, input logic [7:0] st, input logic [3:0] ex, input logic [3:0] mk);
      @(negedge clk);
      ld_we = 1'b1; ld_addr = 5'(addr); ld_data = {st, ex, mk};
      @(negedge clk);
      ld_we = 1'b0;
      m_valid[addr] = 1'b1; m_stim[addr] = st; m_exp[addr] = ex; m_mask[addr] = mk;
   endtask

   task automatic clear_all();
      @(negedge clk);
      clr_vec = 1'b1;
      @(negedge clk);
      clr_vec = 1'b0;
      for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
   endtask

   // Reference: walk slots in order, count checks/errors, stop where the rules say.
   task automatic model(input int inst, output int n, output int ec, output int fi,
                        output int fv, output int cyc);
      bit term;
      n = 0; ec = 0; fi = 0; fv = 0; term = 1'b0;
      for (int i = 0; i < 32; i++) begin
         bit mis;
         if (!m_valid[i]) begin term = 1'b1; break; end
         n++;
         exp_stim[inst] = m_stim[i];
         mis = ((resp[m_stim[i]] ^ m_exp[i]) & m_mask[i]) != 4'd0;
         if (mis) begin
            ec++;
            if (fv == 0) begin fv = 1; fi = i; end
            if (stop_p[inst] != 0) break;
         end
      end
      cyc = n * (lat_p[inst] + 1) + (term ? 1 : 0);
   endtask

   task automatic run_check(input string tag, input bit poke);
      int n[3], ec[3], fi[3], fv[3], cyc[3], seen[3];
      bit all_done;
      for (int i = 0; i < 3; i++) begin
         model(i, n[i], ec[i], fi[i], fv[i], cyc[i]);
         seen[i] = 0;
      end
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      all_done = 1'b0;
      for (int c = 1; c <= 1000 && !all_done; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 3; i++)
            if (done_v[i] && seen[i] == 0) seen[i] = c;
         all_done = (seen[0] != 0) && (seen[1] != 0) && (seen[2] != 0);
         if (poke) begin
            ld_we   = (c == 1);
            ld_addr = 5'd1;
            ld_data = 16'(32'($urandom));
            clr_vec = (c == 2);
         end
      end
      ld_we = 1'b0; clr_vec = 1'b0;
      check_val({tag, "/timeout"}, 32'(all_done), 32'd1);
      for (int i = 0; i < 3; i++) begin
         check_val($sformatf("%s/u%0d/cycles", tag, i), 32'(seen[i]), 32'(cyc[i]));
         check_val($sformatf("%s/u%0d/vec_count", tag, i), 32'(vc_v[i]), 32'(n[i]));
         check_val($sformatf("%s/u%0d/err_count", tag, i), 32'(ec_v[i]), 32'(ec[i]));
         check_val($sformatf("%s/u%0d/first_vld", tag, i), 32'(fvld_v[i]), 32'(fv[i]));
         if (fv[i] != 0)
            check_val($sformatf("%s/u%0d/first_idx", tag, i), 32'(fidx_v[i]), 32'(fi[i]));
         check_val($sformatf("%s/u%0d/busy", tag, i), 32'(busy_v[i]), 32'd0);
         check_val($sformatf("%s/u%0d/stim", tag, i), 32'(stim_v[i]), 32'(exp_stim[i]));
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 3; i++) begin
         check_val($sformatf("%s/u%0d/outs", tag, i),
                   {8'd0, stim_v[i], 2'd0, busy_v[i], done_v[i], vc_v[i], ec_v[i]}, 32'd0);
         check_val($sformatf("%s/u%0d/first", tag, i), {26'd0, fidx_v[i], fvld_v[i]}, 32'd0);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) resp[i] = 4'($urandom);
      for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
      for (int i = 0; i < 3; i++) exp_stim[i] = 8'd0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_val("no_autostart", 32'(done_v[0] | busy_v[0]), 32'd0);

      // Three matching vectors, slot 3 invalid.
      for (int i = 0; i < 3; i++) load(i, 8'(8'h10 + 8'(i)), resp[8'h10 + i], 4'($urandom));
      run_check("match3", 1'b0);

      // Slot 1 expects 0010, DUT gives 0110: full mask fails, 1011 masks it out.
      resp[8'h21] = 4'b0110;
      load(1, 8'h21, 4'b0010, 4'b1111);
      run_check("mask_full", 1'b0);
      load(1, 8'h21, 4'b0010, 4'b1011);
      run_check("mask_part", 1'b0);

      // Six vectors with mismatches at slots 2 and 4.
      clear_all();
      for (int i = 0; i < 6; i++) begin
         logic [7:0] st;
         st = 8'(8'h40 + 8'(i));
         load(i, st, (i == 2 || i == 4) ? ~resp[st] : resp[st], 4'b1111);
      end
      run_check("stop2of6", 1'b0);

      // Loads and clears during a run must be ignored; rerun from DONE sees the same slots.
      clear_all();
      for (int i = 0; i < 5; i++) load(i, 8'(8'h60 + 8'(i)), resp[8'h60 + i], 4'b1111);
      run_check("busy_poke", 1'b1);
      run_check("rerun", 1'b0);

      // Clear wins over a same-cycle write.
      @(negedge clk);
      ld_we = 1'b1; clr_vec = 1'b1; ld_addr = 5'd0; ld_data = 16'h1234;
      @(negedge clk);
      ld_we = 1'b0; clr_vec = 1'b0;
      for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
      run_check("clr_wins", 1'b0);

      // Random tables; the first round fills all 32 slots.
      for (int r = 0; r < 5; r++) begin
         int cnt;
         for (int i = 0; i < 256; i++) resp[i] = 4'($urandom);
         clear_all();
         cnt = (r == 0) ? 32 : int'($urandom_range(1, 32));
         for (int i = 0; i < cnt; i++) begin
            logic [7:0] st;
            logic [3:0] flip;
            st   = 8'($urandom);
            flip = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            load(i, st, resp[st] ^ flip, 4'($urandom));
         end
         run_check($sformatf("rand%0d", r), 1'b0);
      end

      // Reset while the LAT=3 checker waits on vector 5.
      clear_all();
      for (int i = 0; i < 32; i++) load(i, 8'($urandom), 4'd0, 4'd0);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      begin
         bit hit;
         hit = 1'b0;
         for (int c = 0; c < 200 && !hit; c++) begin
            @(posedge clk); #1;
            hit = (vc_v[2] == 6'd5);
         end
         check_val("reach_vec5", 32'(hit), 32'd1);
      end
      @(posedge clk); #1;
      check_val("mid_busy", 32'(busy_v[2]), 32'd1);
      #2 reset = 1'b0;
      #1 check_all_zero("mid_reset");
      #2 reset = 1'b1;
      for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
      for (int i = 0; i < 3; i++) exp_stim[i] = 8'd0;
      repeat (4) @(negedge clk);
      check_val("post_reset_idle", 32'(done_v[2] | busy_v[2]), 32'd0);
      run_check("post_reset", 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
